// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared encodings for the bit-serial comparator
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [1:0] res_t;

  localparam res_t R_EQ = 2'b00;
  localparam res_t R_GT = 2'b01;
  localparam res_t R_LT = 2'b10;

endpackage

// File: rtl/compare_cell.sv
// rtl/compare_cell.sv - one-bit compare step reused every cycle by the serial loop
module compare_cell
  import cmp_pkg::*;
(
  input  res_t p_i,
  input  logic a_i,
  input  logic b_i,
  input  logic dir_i,
  output res_t p_next_o,
  output logic decided_o
);

  logic diff;
  res_t bit_res;

  // LSB-first lets every later (more significant) difference overwrite p;
  // MSB-first keeps the first decision because nothing below can outrank it.
  always_comb begin
    diff      = a_i ^ b_i;
    bit_res   = a_i ? R_GT : R_LT;
    decided_o = diff && (p_i == R_EQ);
    p_next_o  = p_i;
    if (diff) begin
      if (!dir_i) begin
        p_next_o = bit_res;
      end else if (p_i == R_EQ) begin
        p_next_o = bit_res;
      end
    end
  end

endmodule

// File: rtl/bit_serial_comparator.sv
// rtl/bit_serial_comparator.sv - serial unsigned magnitude comparator with start/done handshake
module bit_serial_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             z
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               dir_q;
  logic [CNT_W-1:0]   idx_q;
  res_t               p_q;
  res_t               p_next;
  logic               decided;
  logic               gt_q, eq_q, lt_q;
  logic               last_bit;
  logic               leave_run;
  logic               accept;

  compare_cell u_cell (
    .p_i       (p_q),
    .a_i       (a_q[idx_q]),
    .b_i       (b_q[idx_q]),
    .dir_i     (dir_q),
    .p_next_o  (p_next),
    .decided_o (decided)
  );

  assign last_bit  = dir_q ? (idx_q == '0) : (idx_q == CNT_W'(WIDTH - 1));
  assign leave_run = last_bit || (EARLY_EXIT && dir_q && decided);
  assign accept    = in_ready && start;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE re-enters RUN directly when a new start is waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (leave_run) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
  end

  // Operand latch, bit walk and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      dir_q <= 1'b0;
      idx_q <= '0;
      p_q   <= R_EQ;
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      dir_q <= dir;
      idx_q <= dir ? CNT_W'(WIDTH - 1) : '0;
      p_q   <= R_EQ;
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      p_q <= p_next;
      // Hold idx on the final bit so it never steps outside the word
      if (!last_bit) begin
        idx_q <= dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
      end
      if (leave_run) begin
        gt_q <= (p_next == R_GT);
        eq_q <= (p_next == R_EQ);
        lt_q <= (p_next == R_LT);
      end
    end
  end

  assign gt = gt_q;
  assign eq = eq_q;
  assign lt = lt_q;
  assign z  = gt_q;

endmodule
